// File: rtl/qe_mac_datapath.sv
// qe_mac_datapath: pipelined quadratic evaluator (a*x*x + b*x + c) with saturating stream accumulation
module qe_mac_datapath (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_mode0,
  input  logic               enable_mode1,
  input  logic               valid_in,
  input  logic               last_in,
  input  logic signed [7:0]  x,
  input  logic               coef_load,
  input  logic signed [7:0]  coef_a,
  input  logic signed [7:0]  coef_b,
  input  logic signed [7:0]  coef_c,
  output logic               valid_out,
  output logic signed [31:0] result,
  output logic               done,
  output logic               ovf
);
  typedef enum logic [1:0] {IDLE, EVAL, ACCUM} state_t;
  state_t state, state_n;
  logic signed [7:0]  ca, cb, cc;
  logic               s1_v, s1_l, s1_m;
  logic signed [16:0] s1_xx;
  logic signed [15:0] s1_bx;
  logic signed [7:0]  s1_a, s1_c;
  logic               s2_v, s2_l, s2_m;
  logic signed [24:0] s2_y;
  logic signed [31:0] acc;
  logic               abort_p;
  logic               m0_only, m1_only, accept, drain, clamp;
  logic signed [24:0] y;
  logic signed [32:0] sum;
  logic signed [31:0] sat;
  assign m0_only = enable_mode0 & ~enable_mode1;
  assign m1_only = enable_mode1 & ~enable_mode0;
  assign accept  = valid_in & (enable_mode0 ^ enable_mode1);
  assign y       = 25'(s1_a) * 25'(s1_xx) + 25'(s1_bx) + 25'(s1_c);
  assign sum     = 33'(acc) + 33'(s2_y);
  assign clamp   = sum[32] ^ sum[31];
  assign sat     = clamp ? {sum[32], {31{~sum[32]}}} : sum[31:0];
  // abort cleanup waits until no stream sample remains in S1/S2
  assign drain   = ~(s1_v & s1_m) & ~(s2_v & s2_m);
  always_comb begin
    state_n = IDLE;
    state_n = (state == IDLE) ? (m0_only ? EVAL : m1_only ? ACCUM : IDLE) :
              (state == EVAL && m0_only) ? EVAL :
              (state == ACCUM && m1_only) ? ACCUM : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {ca, cb, cc} <= '0;
      {s1_v, s1_l, s1_m, s1_xx, s1_bx, s1_a, s1_c} <= '0;
      {s2_v, s2_l, s2_m, s2_y} <= '0;
      acc       <= '0;
      abort_p   <= 1'b0;
      result    <= '0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (coef_load) {ca, cb, cc} <= {coef_a, coef_b, coef_c};
      s1_v  <= accept;
      s1_l  <= last_in & enable_mode1;
      s1_m  <= enable_mode1;
      s1_xx <= 17'(x) * 17'(x);
      s1_bx <= 16'(cb) * 16'(x);
      s1_a  <= ca;
      s1_c  <= cc;
      s2_v  <= s1_v;
      s2_l  <= s1_l;
      s2_m  <= s1_m;
      s2_y  <= y;
      valid_out <= s2_v & (~s2_m | s2_l);
      done      <= s2_v & s2_m & s2_l;
      if (s2_v & ~s2_m) result <= 32'(s2_y);
      if (s2_v & s2_m) begin
        acc <= s2_l ? '0 : sat;
        if (s2_l) result <= sat;
      end
      // ovf stays visible with the final result, then clears on the next edge
      ovf <= (abort_p & drain) ? 1'b0 : ((done ? 1'b0 : ovf) | (s2_v & s2_m & clamp));
      if (abort_p & drain) acc <= '0;
      abort_p <= (state == ACCUM && state_n != ACCUM) ? 1'b1 : (drain ? 1'b0 : abort_p);
    end
  end
endmodule

// File: tb/tb_qe_mac_datapath.sv
// tb_qe_mac_datapath: directed scenario bench for qe_mac_datapath
module tb_qe_mac_datapath;
  logic clk = 1'b0;
  logic reset, enable_mode0, enable_mode1, valid_in, last_in, coef_load;
  logic signed [7:0] x, coef_a, coef_b, coef_c;
  logic valid_out, done, ovf;
  logic signed [31:0] result;
  int checks = 0;
  int errors = 0;

  qe_mac_datapath dut (
    .clk(clk), .reset(reset), .enable_mode0(enable_mode0), .enable_mode1(enable_mode1),
    .valid_in(valid_in), .last_in(last_in), .x(x), .coef_load(coef_load),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
    .valid_out(valid_out), .result(result), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic load(input logic signed [7:0] a, b, c);
    coef_load = 1'b1; coef_a = a; coef_b = b; coef_c = c;
    tick();
    coef_load = 1'b0;
  endtask

  task automatic wait_out(input int cyc, output int n, output logic [31:0] r, output logic d, output logic o);
    n = 0; r = '0; d = 1'b0; o = 1'b0;
    repeat (cyc) begin
      tick();
      if (valid_out === 1'b1) begin
        n++; r = result; d = done; o = ovf;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({valid_out, done, ovf} !== 3'b000 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: valid_out=%b done=%b ovf=%b result=%h, expected all 0", valid_out, done, ovf, result);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_mode0;
    load(8'sd1, 8'sd2, 8'sd3);
    enable_mode0 = 1'b1; enable_mode1 = 1'b0;
    valid_in = 1'b1; x = 8'sd4; last_in = 1'b1;
    tick();
    valid_in = 1'b0; last_in = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL mode0_early: valid_out=%b at N+2, expected 0", valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || result !== 32'sd27 || done !== 1'b0) begin
      errors++;
      $display("FAIL mode0_eval: valid_out=%b result=%0d done=%b, expected 1/27/0", valid_out, result, done);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || result !== 32'sd27) begin
      errors++; $display("FAIL mode0_hold: valid_out=%b result=%0d, expected 0/27", valid_out, result);
    end
  endtask

  task automatic test_back_to_back;
    logic signed [31:0] exp_r [3];
    exp_r[0] = 32'sd2; exp_r[1] = 32'sd3; exp_r[2] = 32'sd38;
    valid_in = 1'b1; x = -8'sd1;
    tick();
    x = 8'sd0;
    tick();
    x = 8'sd5;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid_out !== 1'b1 || result !== exp_r[i]) begin
        errors++;
        $display("FAIL b2b_%0d: valid_out=%b result=%0d, expected 1/%0d", i, valid_out, result, exp_r[i]);
      end
      tick();
    end
    enable_mode0 = 1'b0;
  endtask

  task automatic test_mode1_stream;
    int n; logic [31:0] r; logic d, o;
    load(8'sd1, 8'sd0, 8'sd0);
    enable_mode1 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      valid_in = 1'b1; x = 8'(i); last_in = (i == 3);
      tick();
    end
    valid_in = 1'b0; last_in = 1'b0;
    wait_out(8, n, r, d, o);
    checks++;
    if (n !== 1 || r !== 32'd14 || d !== 1'b1 || o !== 1'b0) begin
      errors++;
      $display("FAIL mode1_stream: outputs=%0d result=%0d done=%b ovf=%b, expected 1/14/1/0", n, r, d, o);
    end
    enable_mode1 = 1'b0;
    tick();
  endtask

  task automatic test_saturation;
    int n, early; logic [31:0] r; logic d, o;
    early = 0;
    load(8'sd127, 8'sd127, 8'sd127);
    enable_mode1 = 1'b1;
    for (int i = 0; i < 1041; i++) begin
      valid_in = 1'b1; x = -8'sd128; last_in = (i == 1040);
      tick();
      if (valid_out === 1'b1) early++;
    end
    valid_in = 1'b0; last_in = 1'b0;
    wait_out(6, n, r, d, o);
    checks++;
    if (early !== 0 || n !== 1 || r !== 32'h7FFFFFFF || d !== 1'b1 || o !== 1'b1) begin
      errors++;
      $display("FAIL saturation: early=%0d outputs=%0d result=%h done=%b ovf=%b, expected 0/1/7fffffff/1/1", early, n, r, d, o);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: ovf=%b after stream end, expected 0", ovf);
    end
    enable_mode1 = 1'b0;
    tick();
  endtask

  task automatic test_illegal;
    int n; logic [31:0] r; logic d, o;
    enable_mode0 = 1'b1; enable_mode1 = 1'b1;
    valid_in = 1'b1; x = 8'sd4;
    tick();
    valid_in = 1'b0;
    wait_out(5, n, r, d, o);
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL illegal_enc: outputs=%0d, expected 0", n);
    end
    checks++;
    if (int'(dut.state) !== 0) begin
      errors++; $display("FAIL illegal_state: state=%0d, expected 0 (IDLE)", int'(dut.state));
    end
    enable_mode0 = 1'b0; enable_mode1 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int n; logic [31:0] r; logic d, o;
    load(8'sd1, 8'sd0, 8'sd0);
    enable_mode1 = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      valid_in = 1'b1; x = 8'(i);
      tick();
    end
    valid_in = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({valid_out, done, ovf} !== 3'b000 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: valid_out=%b done=%b ovf=%b result=%h, expected all 0", valid_out, done, ovf, result);
    end
    tick();
    reset = 1'b0;
    wait_out(6, n, r, d, o);
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL reset_drop: outputs=%0d after release, expected 0", n);
    end
    load(8'sd1, 8'sd0, 8'sd0);
    valid_in = 1'b1; x = 8'sd2; last_in = 1'b1;
    tick();
    valid_in = 1'b0; last_in = 1'b0;
    wait_out(6, n, r, d, o);
    checks++;
    if (n !== 1 || r !== 32'd4 || d !== 1'b1) begin
      errors++; $display("FAIL reset_restart: outputs=%0d result=%0d done=%b, expected 1/4/1", n, r, d);
    end
    enable_mode1 = 1'b0;
    tick();
  endtask

  task automatic test_abort;
    int n; logic [31:0] r; logic d, o;
    load(8'sd1, 8'sd0, 8'sd0);
    enable_mode1 = 1'b1;
    valid_in = 1'b1; x = 8'sd3;
    tick();
    x = 8'sd5;
    tick();
    valid_in = 1'b0;
    tick();
    enable_mode1 = 1'b0;
    wait_out(6, n, r, d, o);
    checks++;
    if (n !== 0 || ovf !== 1'b0) begin
      errors++; $display("FAIL abort_silent: outputs=%0d ovf=%b, expected 0/0", n, ovf);
    end
    enable_mode1 = 1'b1;
    valid_in = 1'b1; x = 8'sd2; last_in = 1'b1;
    tick();
    valid_in = 1'b0; last_in = 1'b0;
    wait_out(6, n, r, d, o);
    checks++;
    if (n !== 1 || r !== 32'd4) begin
      errors++; $display("FAIL abort_acc_clear: outputs=%0d result=%0d, expected 1/4", n, r);
    end
    enable_mode1 = 1'b0;
    tick();
    load(8'sd1, 8'sd1, 8'sd1);
    enable_mode0 = 1'b1;
    valid_in = 1'b1; x = 8'sd1;
    tick();
    valid_in = 1'b0;
    wait_out(5, n, r, d, o);
    checks++;
    if (n !== 1 || r !== 32'd3 || d !== 1'b0) begin
      errors++; $display("FAIL abort_mode0: outputs=%0d result=%0d done=%b, expected 1/3/0", n, r, d);
    end
    enable_mode0 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable_mode0 = 1'b0; enable_mode1 = 1'b0; valid_in = 1'b0; last_in = 1'b0;
    x = '0; coef_load = 1'b0; coef_a = '0; coef_b = '0; coef_c = '0;
    tick();
    test_reset();
    test_mode0();
    test_back_to_back();
    test_mode1_stream();
    test_saturation();
    test_illegal();
    test_reset_mid();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qe_mac_datapath.md
QE_MAC_DATAPATH -- requirements
Module: qe_mac_datapath

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- enable_mode0  in  1  per-sample evaluation mode select, from controller
- enable_mode1  in  1  stream-accumulate mode select, from controller
- valid_in  in  1  sample x valid this cycle
- last_in  in  1  final sample of a mode-1 stream; qualified by valid_in
- x  in  8  signed sample
- coef_load  in  1  strobe: capture coef_a/b/c
- coef_a, coef_b, coef_c  in  8 each  signed coefficients
- valid_out  out  1  result valid, one-cycle pulse
- result  out  32  signed y or accumulated sum
- done  out  1  pulses with the valid_out of a completed mode-1 stream
- ovf  out  1  sticky saturation flag for the current stream

Function
REQ-002 The block SHALL compute y = a*x*x + b*x + c in signed two's complement; y is 25 bits signed, sign-extended to 32.
REQ-003 On coef_load=1, the block SHALL register coef_a/b/c; the registered values apply to samples accepted from the next cycle onward.
REQ-004 Sample accept SHALL be valid_in & (enable_mode0 XOR enable_mode1); all other valid_in cycles are dropped without effect.
REQ-005 The pipeline SHALL have 3 register stages.
- S1: x*x (17b), b*x, c
- S2: y
- S3: output/accumulator
- Each stage carries a valid bit, a last bit and a mode bit captured at accept.
REQ-006 Mode 0: an accepted sample at cycle N SHALL produce valid_out=1 with result=y at cycle N+3; throughput is one sample per cycle.
REQ-007 Mode 1: each S3 entry SHALL update acc <= sat32(acc + y).
- No valid_out for non-last samples.
- For the last sample: result=sat32(acc+y), valid_out=1 and done=1 at cycle N+3.
- acc then clears to 0.
REQ-008 Saturation SHALL clamp to 0x7FFFFFFF / 0x80000000. ovf SHALL set on any clamp, hold until the last sample of the stream has been output, and be visible alongside that result.
REQ-009 States SHALL be:
- IDLE: no accepts.
- EVAL: enable_mode0 only.
- ACCUM: enable_mode1 only.
- IDLE to EVAL/ACCUM when the corresponding single enable rises.
- Any change of enable encoding SHALL return to IDLE the next cycle.
REQ-010 Samples already in flight when a mode change occurs SHALL complete under their captured mode bit.
REQ-011 On leaving ACCUM before a last sample reaches S3, the block SHALL clear acc and ovf once in-flight samples drain, and SHALL emit no result.
REQ-012 When last_in is asserted on a sample accepted in mode 0, last_in SHALL be ignored.
REQ-013 Outside a valid_out cycle, result SHALL hold its previous value and valid_out/done SHALL be 0.

Reset
REQ-014 While reset=1, the block SHALL force the following to 0 asynchronously: all pipeline valid bits, acc, coefficients, result, valid_out, done and ovf; the state SHALL be IDLE.
REQ-015 Reset mid-stream SHALL discard all in-flight samples. No output SHALL appear for them after release.
REQ-016 After reset release, the first accept SHALL be possible on the first clock edge at which REQ-004 holds.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Mode-0 evaluation: a=1, b=2, c=3 loaded; x=4 accepted at cycle N -> valid_out=1, result=27 at N+3, done=0.
- Mode-1 stream: a=1, b=0, c=0; x=1, 2, 3 back-to-back, last on 3 -> single valid_out with result=14, done=1, ovf=0.
- Saturation: a=b=c=127; 1041 samples of x=-128 in mode 1, last on the final one -> result=0x7FFFFFFF, ovf=1, done=1.
- Illegal enable encoding: enable_mode0=enable_mode1=1 with valid_in -> no valid_out within 5 cycles; state IDLE.
- Reset mid-stream: reset pulse after 2 of 3 mode-1 samples -> all outputs 0 immediately; no valid_out after release; a new stream x=2 (last), a=1 -> result=4.
- Abort: enable_mode1 drops before last -> no output; a following mode-0 sample x=1 with a=b=c=1 -> result=3.
